// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and select encoding for the hazard/forwarding unit.
// FWD_POST_WB_EN enables the post-writeback stage record in the top.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;
    localparam logic [1:0] FWD_PWB = 2'd3;

    typedef enum logic {
        RUN,
        STALL
    } fsm_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_rec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_rec_t;

    function automatic stage_rec_t ex_to_stage(input ex_rec_t ex);
        return '{valid: ex.valid, rd: ex.rd, reg_write: ex.reg_write, mem_read: ex.mem_read};
    endfunction

    function automatic logic can_forward(input stage_rec_t rec);
        return rec.valid && rec.reg_write;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// Priority select for one EX source register: MEM, then WB, then PWB (FWD_POST_WB_EN).
module fwd_match
    import hazard_forward_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       mem_en,
    input  logic [4:0] mem_rd,
    input  logic       wb_en,
    input  logic [4:0] wb_rd,
`ifdef FWD_POST_WB_EN
    input  logic       pwb_en,
    input  logic [4:0] pwb_rd,
`endif
    output logic [1:0] sel
);

    // x0 is never forwarded, so a zero source short-circuits every stage match
    always_comb begin
        sel = FWD_RF;
        if (rs != '0) begin
            if (mem_en && mem_rd == rs)
                sel = FWD_MEM;
            else if (wb_en && wb_rd == rs)
                sel = FWD_WB;
`ifdef FWD_POST_WB_EN
            else if (pwb_en && pwb_rd == rs)
                sel = FWD_PWB;
`endif
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and ALU operand forwarding selects; no datapath.
// FWD_POST_WB_EN adds the post-writeback record and select 3.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic [15:0] stall_count
);

    ex_rec_t    ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;
`ifdef FWD_POST_WB_EN
    stage_rec_t pwb_q;
    logic       unused_pwb_mem_read;
    assign unused_pwb_mem_read = pwb_q.mem_read;
`else
    logic       unused_wb_mem_read;
    assign unused_wb_mem_read = wb_q.mem_read;
`endif

    fsm_state_t  state_q, state_d;
    logic        load_use;
    logic        count_inc;
    logic [15:0] stall_count_q;
    logic        mem_fwd_en;

    always_comb begin
        load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)
                   && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    end

    assign stall = load_use && !flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
`ifdef FWD_POST_WB_EN
            pwb_q <= '0;
`endif
        end else begin
            if (stall || flush)
                ex_q <= '0;
            else
                ex_q <= '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                          mem_read: id_mem_read, rs1: id_rs1, rs2: id_rs2};
            mem_q <= ex_to_stage(ex_q);
            wb_q  <= mem_q;
`ifdef FWD_POST_WB_EN
            pwb_q <= wb_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall) state_d = STALL;
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        count_inc = (state_q == RUN) && (state_d == STALL);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_count_q <= '0;
        else if (count_inc && stall_count_q != '1)
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign stall_count = stall_count_q;

    // Load data is not ready in MEM; it is picked up from WB one cycle later
    assign mem_fwd_en = can_forward(mem_q) && !mem_q.mem_read;

    fwd_match u_match_a (
        .rs     (ex_q.rs1),
        .mem_en (mem_fwd_en),
        .mem_rd (mem_q.rd),
        .wb_en  (can_forward(wb_q)),
        .wb_rd  (wb_q.rd),
`ifdef FWD_POST_WB_EN
        .pwb_en (can_forward(pwb_q)),
        .pwb_rd (pwb_q.rd),
`endif
        .sel    (fwd_a_sel)
    );

    fwd_match u_match_b (
        .rs     (ex_q.rs2),
        .mem_en (mem_fwd_en),
        .mem_rd (mem_q.rd),
        .wb_en  (can_forward(wb_q)),
        .wb_rd  (wb_q.rd),
`ifdef FWD_POST_WB_EN
        .pwb_en (can_forward(pwb_q)),
        .pwb_rd (pwb_q.rd),
`endif
        .sel    (fwd_b_sel)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit.
// Expected PWB select follows FWD_POST_WB_EN.
module tb_hazard_forward_unit;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;
    logic [15:0] stall_count;

`ifdef FWD_POST_WB_EN
    localparam logic [1:0] EXP_PWB = 2'd3;
`else
    localparam logic [1:0] EXP_PWB = 2'd0;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_forward_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        flush   = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) step();
        reset_n = 1'b1;
        check("rst_fwd_a", 16'(fwd_a_sel), 16'd0);
        check("rst_fwd_b", 16'(fwd_b_sel), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_count", stall_count, 16'd0);

        // Scenario 1: ALU result forwarded from MEM
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        check("s1_stall", 16'(stall), 16'd0);
        step();
        check("s1_fwd_a", 16'(fwd_a_sel), 16'd1);
        check("s1_fwd_b", 16'(fwd_b_sel), 16'd0);

        // Scenario 2: load-use stall, then WB forward
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        check("s2_stall_on", 16'(stall), 16'd1);
        check("s2_count_before", stall_count, 16'd0);
        step();
        check("s2_stall_off", 16'(stall), 16'd0);
        check("s2_count_after", stall_count, 16'd1);
        step();
        check("s2_fwd_b", 16'(fwd_b_sel), 16'd2);
        check("s2_fwd_a", 16'(fwd_a_sel), 16'd0);

        // Scenario 3: MEM beats WB; then WB vs MEM on separate operands; then PWB
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0);
        step();
        check("s3_mem_prio", 16'(fwd_a_sel), 16'd1);

        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 5'd4, 5'd10, 1'b1, 1'b0);
        step();
        check("s3_wb_a", 16'(fwd_a_sel), 16'd2);
        check("s3_mem_b", 16'(fwd_b_sel), 16'd1);

        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        set_id(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0);
        step();
        check("s3_pwb_a", 16'(fwd_a_sel), 16'(EXP_PWB));

        // Scenario 4: x0 is never forwarded nor stalled on
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        check("s4_alu_stall", 16'(stall), 16'd0);
        step();
        check("s4_alu_fwd_a", 16'(fwd_a_sel), 16'd0);
        check("s4_alu_fwd_b", 16'(fwd_b_sel), 16'd0);
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        check("s4_ld_stall", 16'(stall), 16'd0);
        step();
        check("s4_ld_fwd_a", 16'(fwd_a_sel), 16'd0);
        check("s4_ld_fwd_b", 16'(fwd_b_sel), 16'd0);
        check("s4_count", stall_count, 16'd1);

        // Scenario 5: flush overrides the load-use stall
        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("s5_stall", 16'(stall), 16'd0);
        step();
        flush = 1'b0;
        set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
        check("s5_no_stall_after", 16'(stall), 16'd0);
        step();
        check("s5_bubble_fwd_a", 16'(fwd_a_sel), 16'd0);
        check("s5_count", stall_count, 16'd1);

        // Scenario 6: saturation, then reset taken in a stall cycle
        drain();
        force dut.stall_count_q = 16'hFFFE;
        step();
        release dut.stall_count_q;
        check("s6_preload", stall_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
            step();
            set_id(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
            check($sformatf("s6_stall_%0d", k), 16'(stall), 16'd1);
            step();
            check($sformatf("s6_count_%0d", k), stall_count, 16'hFFFF);
            set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            step();
        end

        drain();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        check("s6_pre_rst_fwd_a", 16'(fwd_a_sel), 16'd1);
        set_id(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0);
        check("s6_pre_rst_stall", 16'(stall), 16'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("s6_rst_count", stall_count, 16'd0);
        check("s6_rst_fwd_a", 16'(fwd_a_sel), 16'd0);
        check("s6_rst_fwd_b", 16'(fwd_b_sel), 16'd0);
        check("s6_rst_stall", 16'(stall), 16'd0);
        step();
        check("s6_run_count", stall_count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 clk  input  1  pipeline clock; every register updates on the rising edge.
REQ-002 reset_n  input  1  reset, synchronous and active-low.
REQ-003 id_valid  input  1  a real instruction is leaving ID this cycle.
REQ-004 id_rs1, id_rs2  input  5 each  source registers of the ID instruction.
REQ-005 id_rd  input  5  destination register of the ID instruction.
REQ-006 id_reg_write  input  1  ID instruction writes id_rd.
REQ-007 id_mem_read  input  1  ID instruction is a load.
REQ-008 flush  input  1  branch or jump redirect; kills the instruction entering EX.
REQ-009 fwd_a_sel, fwd_b_sel  output  2 each  select lines for the 4:1 ALU operand muxes of operands A and B.
REQ-010 stall  output  1  hold PC and IF/ID this cycle.
REQ-011 stall_count  output  16  number of load-use stalls taken.

Function
REQ-012 The unit SHALL hold four stage records: EX, MEM, WB and PWB (post-writeback). Each record has valid, rd, reg_write and mem_read; the EX record also has rs1 and rs2.
REQ-013 In each unstalled, unflushed cycle: EX <= ID fields with valid = id_valid; MEM <= EX; WB <= MEM; PWB <= WB.
REQ-014 Select encoding SHALL be: 0 = register file, 1 = MEM-stage ALU result, 2 = WB result, 3 = PWB buffered result.
REQ-015 fwd_a_sel SHALL be combinational from registered state only, so the latency to the mux is 0 cycles after the EX record loads.
REQ-016 fwd_a_sel priority SHALL be: MEM match (1), else WB match (2), else PWB match (3), else 0.
REQ-017 A match SHALL require all of: stage valid, reg_write, rd equal to ex_rs1, and rd not equal to 0.
REQ-018 fwd_b_sel SHALL follow the same rule as fwd_a_sel using ex_rs2.
REQ-019 A load-use hazard SHALL exist when all of the following hold: id_valid, EX valid, ex_mem_read, ex_rd not equal to 0, and ex_rd equal to id_rs1 or id_rs2.
REQ-020 stall SHALL equal (load-use hazard) AND NOT flush.
REQ-021 While stall is high: EX <= bubble (valid = 0); MEM, WB and PWB advance normally.
REQ-022 flush SHALL load EX with a bubble. If flush and a load-use hazard occur together, flush wins: stall = 0 and no count.
REQ-023 FSM: RUN to STALL on stall. STALL to RUN unconditionally after 1 cycle. state = STALL means the previous cycle was a stall.
REQ-024 stall_count SHALL increment by 1 on each RUN-to-STALL transition and saturate at 0xFFFF with no wrap.
REQ-025 A load in MEM SHALL never select 1; its data is first forwarded from WB (select 2).

Reset
REQ-026 While reset_n = 0 at a clock edge: all stage valid bits clear, state = RUN, stall_count = 0.
REQ-027 After that reset edge: fwd_a_sel = 0, fwd_b_sel = 0, stall = 0.
REQ-028 A reset asserted during a STALL cycle SHALL abandon the stall; the next cycle is RUN with empty stages.

Configuration
REQ-029 Macro FWD_POST_WB_EN SHALL control the PWB stage.
REQ-030 With FWD_POST_WB_EN defined: the PWB record exists and select 3 is produced per REQ-016.
REQ-031 Without FWD_POST_WB_EN: the PWB record is not built, select 3 is never driven, and the register file is treated as write-through.

Structure
REQ-032 A shared package SHALL hold:
- the select encoding constants FWD_RF, FWD_MEM, FWD_WB, FWD_PWB;
- the FSM state typedef (RUN, STALL);
- the stage-record struct typedef.
REQ-033 One sub-module, fwd_match, SHALL compute the 2-bit select for one source register and SHALL be instantiated twice.
REQ-034 No datapath values SHALL pass through this block; the 32-bit data stays in the operand muxes.

Verification
REQ-035 Scenario 1: add x5 in ID, then sub rs1 = x5 the next cycle -> fwd_a_sel = 1 while sub is in EX; stall = 0.
REQ-036 Scenario 2: lw x7 followed immediately by add rs2 = x7 -> stall = 1 for exactly 1 cycle and stall_count goes 0 to 1; then fwd_b_sel = 2 with add in EX.
REQ-037 Scenario 3: x3 written by the instructions in MEM and in WB, add rs1 = x3 in EX -> fwd_a_sel = 1 (MEM has priority).
REQ-038 Scenario 4: a writer to rd = 0 followed by a reader of x0 -> both selects stay 0 and stall = 0, including when the writer is a load.
REQ-039 Scenario 5: load-use hazard with flush = 1 in the same cycle -> stall = 0, EX becomes a bubble, stall_count unchanged.
REQ-040 Scenario 6: preload stall_count = 0xFFFE, take 3 load-use stalls -> count reads 0xFFFF; then reset_n = 0 for 1 edge -> count = 0 and all selects = 0.
